// File: rtl/light_hash_sched.sv
// Schedules whole byte messages from two requesters through one shared hash core, round-robin per message.
// Latency: a request seen in IDLE gives the init strobe next cycle and the first absorb strobe 3 cycles later.
// Backpressure: only the granted requester sees req_ready, and only in GET; the digest is held until dig_ack.
module light_hash_sched #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_byte,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic        dig_valid,
    output logic        dig_id,
    output logic [63:0] dig_data,
    input  logic        dig_ack,
    output logic        err_timeout,
    output logic        core_valid,
    output logic [1:0]  core_state,
    output logic [7:0]  core_byte,
    input  logic        core_busy,
    input  logic [63:0] core_digest,
    input  logic        core_digest_ready
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        GET,
        SEND,
        BUSY,
        FINAL,
        WAIT_DIG,
        OUT
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_grant;
    logic        r_prio;
    logic        r_last;
    logic        r_busy_first;
    logic [7:0]  r_cnt;
    logic [1:0]  r_core_state;
    logic [7:0]  r_core_byte;
    logic        r_dig_id;
    logic [63:0] r_dig_data;

    logic        w_any_req;
    logic        w_arb_grant;
    logic        w_sel_vld;
    logic        w_sel_last;
    logic [7:0]  w_sel_byte;
    logic        w_busy_done;
    logic        w_timeout;
    logic [1:0]  w_req_ready;
    logic        w_core_valid;
    logic        w_dig_valid;

    // On contention the pointer decides; a lone requester always wins.
    assign w_any_req   = |req_valid;
    assign w_arb_grant = (&req_valid) ? r_prio : req_valid[1];

    assign w_sel_vld   = req_valid[r_grant];
    assign w_sel_last  = req_last[r_grant];
    assign w_sel_byte  = r_grant ? req_byte[15:8] : req_byte[7:0];

    // The first BUSY cycle is skipped because the core raises core_busy one cycle late.
    assign w_busy_done = !r_busy_first && !core_busy;
    assign w_timeout   = (r_state == WAIT_DIG) && !core_digest_ready && (r_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_req_ready  = 2'b00;
        w_core_valid = 1'b0;
        w_dig_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next = INIT;
                end
            end
            INIT: begin
                w_core_valid = 1'b1;
                w_next       = GET;
            end
            GET: begin
                w_req_ready = r_grant ? 2'b10 : 2'b01;
                if (w_sel_vld) begin
                    w_next = SEND;
                end
            end
            SEND: begin
                w_core_valid = 1'b1;
                w_next       = BUSY;
            end
            BUSY: begin
                if (w_busy_done) begin
                    w_next = r_last ? FINAL : GET;
                end
            end
            FINAL: begin
                w_core_valid = 1'b1;
                w_next       = WAIT_DIG;
            end
            WAIT_DIG: begin
                if (core_digest_ready) begin
                    w_next = OUT;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            OUT: begin
                w_dig_valid = 1'b1;
                if (dig_ack) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Command fields load on the edge that enters the strobe state, so they hold between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= 1'b0;
            r_prio       <= 1'b0;
            r_last       <= 1'b0;
            r_busy_first <= 1'b0;
            r_cnt        <= '0;
            r_core_state <= 2'b00;
            r_core_byte  <= '0;
            r_dig_id     <= 1'b0;
            r_dig_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant      <= w_arb_grant;
                        r_prio       <= ~w_arb_grant;
                        r_core_state <= 2'b00;
                    end
                end
                GET: begin
                    if (w_sel_vld) begin
                        r_core_byte  <= w_sel_byte;
                        r_core_state <= 2'b10;
                        r_last       <= w_sel_last;
                    end
                end
                SEND: begin
                    r_busy_first <= 1'b1;
                end
                BUSY: begin
                    r_busy_first <= 1'b0;
                    if (w_busy_done && r_last) begin
                        r_core_state <= 2'b01;
                    end
                end
                FINAL: begin
                    r_cnt <= '0;
                end
                WAIT_DIG: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (core_digest_ready) begin
                        r_dig_data <= core_digest;
                        r_dig_id   <= r_grant;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready   = w_req_ready;
    assign core_valid  = w_core_valid;
    assign core_state  = r_core_state;
    assign core_byte   = r_core_byte;
    assign dig_valid   = w_dig_valid;
    assign dig_id      = r_dig_id;
    assign dig_data    = r_dig_data;
    assign err_timeout = w_timeout;

endmodule

// File: tb/tb_light_hash_sched.sv
// Scoreboard bench for light_hash_sched: expected core strobes, digests and timeouts are queued at stimulus time.
// A behavioural hash core and an ack driver run alongside; a negedge monitor pops and compares every DUT event.
// Requesters hold their byte until req_ready is seen, so backpressure comes entirely from the DUT.
module tb_light_hash_sched;

    localparam int          TMO   = 16;
    localparam logic [63:0] SEED  = 64'hcbf29ce484222325;
    localparam logic [63:0] PRIME = 64'h00000100000001b3;
    localparam logic [1:0]  K_CMD = 2'd0;
    localparam logic [1:0]  K_DIG = 2'd1;
    localparam logic [1:0]  K_TMO = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  st;
        logic [7:0]  b;
        logic        id;
        logic [63:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld0, vld1, lst0, lst1;
    logic [7:0]  byt0, byt1;
    logic [1:0]  req_ready;
    logic        dig_valid, dig_id, dig_ack, err_timeout;
    logic [63:0] dig_data;
    logic        core_valid, core_busy, core_digest_ready;
    logic [1:0]  core_state;
    logic [7:0]  core_byte;
    logic [63:0] core_digest;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_req0 = 0;
    int   first_abs_cyc = 0;
    int   final_cyc = 0;
    int   abs_cnt = 0;
    int   ack_delay = 1;
    int   spur_req = 0;
    bit   en_digest = 1'b1;
    bit   abort = 1'b0;
    bit   done0 = 1'b0;

    light_hash_sched #(.TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        ({vld1, vld0}),
        .req_byte         ({byt1, byt0}),
        .req_last         ({lst1, lst0}),
        .req_ready        (req_ready),
        .dig_valid        (dig_valid),
        .dig_id           (dig_id),
        .dig_data         (dig_data),
        .dig_ack          (dig_ack),
        .err_timeout      (err_timeout),
        .core_valid       (core_valid),
        .core_state       (core_state),
        .core_byte        (core_byte),
        .core_busy        (core_busy),
        .core_digest      (core_digest),
        .core_digest_ready(core_digest_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] hstep(input logic [63:0] h, input logic [7:0] b);
        return (h ^ {56'd0, b}) * PRIME;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [1:0] st, input logic [7:0] b,
                           input logic id, input logic [63:0] d);
        exp_t e;
        e.kind = kind; e.st = st; e.b = b; e.id = id; e.d = d;
        exp_q.push_back(e);
    endtask

    // Expected strobes for a whole message, ending in a digest or a timeout.
    task automatic exp_msg(input int id, input string s, input bit dig);
        logic [63:0] h;
        h = SEED;
        push_ev(K_CMD, 2'b00, 8'h00, 1'b0, 64'd0);
        for (int i = 0; i < s.len(); i++) begin
            push_ev(K_CMD, 2'b10, s[i], 1'b0, 64'd0);
            h = hstep(h, s[i]);
        end
        push_ev(K_CMD, 2'b01, 8'h00, 1'b0, 64'd0);
        if (dig) push_ev(K_DIG, 2'b00, 8'h00, id[0], h);
        else     push_ev(K_TMO, 2'b00, 8'h00, 1'b0, 64'd0);
    endtask

    task automatic pop_exp(input logic [1:0] kind, output exp_t e, output bit ok);
        chk("event_expected", 64'(exp_q.size() != 0), 64'd1);
        ok = 1'b0;
        e.kind = 2'd3; e.st = 2'd0; e.b = 8'd0; e.id = 1'b0; e.d = 64'd0;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            ok = 1'b1;
            chk("event_kind", 64'(kind), 64'(e.kind));
        end
    endtask

    task automatic send_byte(input int id, input logic [7:0] b, input logic last, input bit first);
        int t;
        t = 0;
        @(negedge clk);
        if (id == 0) begin
            vld0 = 1'b1; byt0 = b; lst0 = last;
            if (first) t_req0 = cyc;
        end else begin
            vld1 = 1'b1; byt1 = b; lst1 = last;
        end
        while (!req_ready[id] && !abort && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("req_accept_wait", 64'(t < 3000), 64'd1);
        if (!abort) begin
            @(posedge clk);
            #1;
        end
        if (id == 0) begin vld0 = 1'b0; lst0 = 1'b0; end
        else         begin vld1 = 1'b0; lst1 = 1'b0; end
    endtask

    task automatic send_msg(input int id, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (abort) return;
            send_byte(id, s[i], i == s.len() - 1, i == 0);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || dig_valid || dig_ack) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", 64'(t < 2000), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready",   64'(req_ready),   64'd0);
        chk("rst_core_valid",  64'(core_valid),  64'd0);
        chk("rst_core_state",  64'(core_state),  64'd0);
        chk("rst_core_byte",   64'(core_byte),   64'd0);
        chk("rst_dig_valid",   64'(dig_valid),   64'd0);
        chk("rst_dig_id",      64'(dig_id),      64'd0);
        chk("rst_dig_data",    dig_data,         64'd0);
        chk("rst_err_timeout", 64'(err_timeout), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Behavioural hash core: 3 cycles of core_busy per byte, digest 4 cycles after finalize.
    initial begin
        int          busy_cnt;
        int          dcnt;
        int          spur_done;
        logic [63:0] h;
        busy_cnt = 0; dcnt = 0; spur_done = 0; h = SEED;
        core_busy = 1'b0; core_digest_ready = 1'b0; core_digest = 64'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                core_busy = 1'b0; core_digest_ready = 1'b0; busy_cnt = 0; dcnt = 0;
            end else begin
                core_digest_ready = 1'b0;
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    core_busy = (busy_cnt != 0);
                end
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0) begin
                        core_digest = h; core_digest_ready = 1'b1;
                    end
                end
                if (spur_done != spur_req) begin
                    spur_done = spur_req;
                    core_digest = 64'hdead_beef_0bad_f00d; core_digest_ready = 1'b1;
                end
                if (core_valid) begin
                    case (core_state)
                        2'b00: h = SEED;
                        2'b10: begin h = hstep(h, core_byte); busy_cnt = 3; core_busy = 1'b1; end
                        2'b01: if (en_digest) dcnt = 4;
                        default: ;
                    endcase
                end
            end
        end
    end

    initial begin
        int ack_wait;
        ack_wait = 0;
        dig_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (dig_ack) begin
                dig_ack = 1'b0; ack_wait = 0;
            end else if (dig_valid && !rst) begin
                if (ack_wait >= ack_delay) dig_ack = 1'b1;
                ack_wait++;
            end else begin
                ack_wait = 0;
            end
        end
    end

    initial begin
        exp_t e;
        bit   ok;
        bit   dig_prev;
        bit   want_first;
        logic        cur_id;
        logic [63:0] cur_d;
        dig_prev = 1'b0; want_first = 1'b0; cur_id = 1'b0; cur_d = 64'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dig_prev = 1'b0; want_first = 1'b0;
            end else begin
                if (core_valid) begin
                    if (core_state == 2'b00) want_first = 1'b1;
                    if (core_state == 2'b10) begin
                        abs_cnt++;
                        if (want_first) begin first_abs_cyc = cyc; want_first = 1'b0; end
                    end
                    if (core_state == 2'b01) final_cyc = cyc;
                    pop_exp(K_CMD, e, ok);
                    if (ok) begin
                        chk("core_state", 64'(core_state), 64'(e.st));
                        if (e.st == 2'b10) chk("core_byte", 64'(core_byte), 64'(e.b));
                    end
                end
                if (dig_valid && !dig_prev) begin
                    pop_exp(K_DIG, e, ok);
                    if (ok) begin cur_id = e.id; cur_d = e.d; end
                end
                if (dig_valid) begin
                    chk("dig_id",            64'(dig_id),     64'(cur_id));
                    chk("dig_data",          dig_data,        cur_d);
                    chk("req_ready_in_out",  64'(req_ready),  64'd0);
                    chk("core_valid_in_out", 64'(core_valid), 64'd0);
                end
                if (err_timeout) begin
                    pop_exp(K_TMO, e, ok);
                    chk("timeout_delay", 64'(cyc - final_cyc), 64'(TMO));
                end
                dig_prev = dig_valid;
            end
        end
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int t;
        rst = 1'b1;
        vld0 = 1'b0; vld1 = 1'b0; lst0 = 1'b0; lst1 = 1'b0; byt0 = 8'h00; byt1 = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;

        // Single requester, three bytes, with noise on the idle requester.
        exp_msg(0, "abc", 1'b1);
        done0 = 1'b0;
        fork
            begin send_msg(0, "abc"); done0 = 1'b1; end
            begin
                while (!done0) begin
                    @(negedge clk);
                    vld1 = 1'($urandom_range(0, 1));
                    byt1 = 8'($urandom);
                    chk("nongrant_ready", 64'(req_ready[1]), 64'd0);
                end
                vld1 = 1'b0;
            end
        join
        drain();
        chk("absorb_latency", 64'(first_abs_cyc - t_req0), 64'd3);

        // Contention after reset, then again to see alternation.
        do_reset();
        exp_msg(0, "p", 1'b1);
        exp_msg(1, "qr", 1'b1);
        fork
            send_msg(0, "p");
            send_msg(1, "qr");
        join
        drain();
        exp_msg(0, "st", 1'b1);
        exp_msg(1, "u", 1'b1);
        fork
            send_msg(0, "st");
            send_msg(1, "u");
        join
        drain();

        // Core never answers finalize.
        en_digest = 1'b0;
        exp_msg(0, "x", 1'b0);
        send_msg(0, "x");
        drain();
        chk("dig_valid_after_timeout", 64'(dig_valid), 64'd0);
        chk("req_ready_after_timeout", 64'(req_ready), 64'd0);
        en_digest = 1'b1;

        // Ack withheld with the other requester waiting and a stray digest_ready.
        exp_msg(1, "k", 1'b1);
        exp_msg(0, "hi", 1'b1);
        ack_delay = 10;
        fork
            send_msg(0, "hi");
            send_msg(1, "k");
            begin
                t = 0;
                while (!dig_valid && t < 2000) begin @(negedge clk); t++; end
                chk("out_reached", 64'(t < 2000), 64'd1);
                spur_req++;
            end
        join
        drain();
        ack_delay = 1;

        // Reset while the core is busy on byte 2.
        base = abs_cnt;
        push_ev(K_CMD, 2'b00, 8'h00, 1'b0, 64'd0);
        push_ev(K_CMD, 2'b10, 8'h61, 1'b0, 64'd0);
        push_ev(K_CMD, 2'b10, 8'h62, 1'b0, 64'd0);
        fork
            send_msg(0, "abc");
            begin
                t = 0;
                while (abs_cnt < base + 2 && t < 2000) begin @(negedge clk); t++; end
                chk("second_absorb_seen", 64'(t < 2000), 64'd1);
                @(negedge clk);
                rst = 1'b1;
                abort = 1'b1;
                @(negedge clk);
                chk_reset_outputs();
                rst = 1'b0;
            end
        join
        abort = 1'b0;
        drain();
        exp_msg(0, "z", 1'b1);
        send_msg(0, "z");
        drain();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
